// File: rtl/clock_reset_seq_pkg.sv
// Shared types and constants for the clock generator reset sequencer.
// State encoding is fixed so debug probes can decode the 2-bit state directly.
package clock_reset_seq_pkg;

    typedef enum logic [1:0] {
        PULSE     = 2'd0,
        WAIT_LOCK = 2'd1,
        STABLE    = 2'd2,
        RUN       = 2'd3
    } state_t;

    localparam int EVT_W = 8;
    localparam logic [EVT_W-1:0] EVT_MAX = '1;

    // Debug event counters stick at full scale instead of wrapping.
    function automatic logic [EVT_W-1:0] sat_inc(input logic [EVT_W-1:0] v);
        return (v == EVT_MAX) ? v : v + EVT_W'(1);
    endfunction

endpackage

// File: rtl/clock_reset_seq_if.sv
// Lock inputs, reset outputs and debug counters between the sequencer and its
// surroundings; the sequencer takes the master side.
interface clock_reset_seq_if;
    import clock_reset_seq_pkg::*;

    logic             pll_lock;
    logic             mmcm_lock;
    logic             clk_rst;
    logic             sys_rst;
    logic             ready;
    logic [EVT_W-1:0] relock_count;
    logic [EVT_W-1:0] timeout_count;

    modport master (
        input  pll_lock, mmcm_lock,
        output clk_rst, sys_rst, ready, relock_count, timeout_count
    );

    modport slave (
        output pll_lock, mmcm_lock,
        input  clk_rst, sys_rst, ready, relock_count, timeout_count
    );

endinterface

// File: rtl/clock_reset_seq_sync_2ff.sv
// Single-bit two-flop synchronizer for lock flags arriving from another domain.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/clock_reset_seq.sv
// Reset sequencer: pulses the clock generator reset, waits for both locks to
// settle, then releases system reset; retries on timeout or loss of lock.
module clock_reset_seq
    import clock_reset_seq_pkg::*;
#(
    parameter int RST_PULSE_CYCLES    = 16,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 65536,
    parameter int CNT_W               = 17
) (
    input  logic               clk,
    input  logic               rst,
    clock_reset_seq_if.master  bus
);

    localparam logic [CNT_W-1:0] PULSE_LAST   = CNT_W'(RST_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             pll_sync, mmcm_sync, lock_ok;
    logic             timeout_evt, relock_evt;
    logic             clk_rst_q, sys_rst_q, ready_q;
    logic [EVT_W-1:0] relock_q, timeout_q;

    sync_2ff u_sync_pll  (.clk(clk), .rst(rst), .d(bus.pll_lock),  .q(pll_sync));
    sync_2ff u_sync_mmcm (.clk(clk), .rst(rst), .d(bus.mmcm_lock), .q(mmcm_sync));

    assign lock_ok = pll_sync & mmcm_sync;

    // A lock drop beats the stable terminal count, and a lock arrival beats
    // the timeout terminal count, so the sequence never pulses needlessly.
    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt + CNT_W'(1);
        timeout_evt = 1'b0;
        relock_evt  = 1'b0;
        unique case (state)
            PULSE: begin
                if (cnt == PULSE_LAST) begin
                    state_nx = WAIT_LOCK;
                    cnt_nx   = '0;
                end
            end
            WAIT_LOCK: begin
                if (lock_ok) begin
                    state_nx = STABLE;
                    cnt_nx   = '0;
                end else if (cnt == TIMEOUT_LAST) begin
                    state_nx    = PULSE;
                    cnt_nx      = '0;
                    timeout_evt = 1'b1;
                end
            end
            STABLE: begin
                if (!lock_ok) begin
                    state_nx = WAIT_LOCK;
                    cnt_nx   = '0;
                end else if (cnt == STABLE_LAST) begin
                    state_nx = RUN;
                    cnt_nx   = '0;
                end
            end
            RUN: begin
                cnt_nx = '0;
                if (!lock_ok) begin
                    state_nx   = PULSE;
                    relock_evt = 1'b1;
                end
            end
            default: begin
                state_nx = PULSE;
                cnt_nx   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they switch with the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= PULSE;
            cnt       <= '0;
            clk_rst_q <= 1'b1;
            sys_rst_q <= 1'b1;
            ready_q   <= 1'b0;
            relock_q  <= '0;
            timeout_q <= '0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            clk_rst_q <= (state_nx == PULSE);
            sys_rst_q <= (state_nx != RUN);
            ready_q   <= (state_nx == RUN);
            if (relock_evt)  relock_q  <= sat_inc(relock_q);
            if (timeout_evt) timeout_q <= sat_inc(timeout_q);
        end
    end

    assign bus.clk_rst       = clk_rst_q;
    assign bus.sys_rst       = sys_rst_q;
    assign bus.ready         = ready_q;
    assign bus.relock_count  = relock_q;
    assign bus.timeout_count = timeout_q;

endmodule

// File: tb/tb_clock_reset_seq.sv
// Bench for clock_reset_seq: directed scenarios with hand-computed edge times,
// then randomized lock activity checked every cycle against a reference model.
module tb_clock_reset_seq;

    localparam int P = 4;
    localparam int S = 8;
    localparam int T = 20;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    clock_reset_seq_if bus ();

    clock_reset_seq #(
        .RST_PULSE_CYCLES   (P),
        .LOCK_STABLE_CYCLES (S),
        .LOCK_TIMEOUT_CYCLES(T),
        .CNT_W              (17)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Reference model: phase plus edges spent in it, locks seen two edges late.
    typedef enum {M_PULSE, M_WAIT, M_STABLE, M_RUN} mdl_phase_t;
    mdl_phase_t m_phase = M_PULSE;
    int m_elapsed = 0;
    int m_relock = 0;
    int m_timeout = 0;
    bit seen1 = 1'b0;
    bit seen2 = 1'b0;

    task automatic modelEnter(input mdl_phase_t ph);
        m_phase   = ph;
        m_elapsed = 0;
    endtask

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                modelEnter(M_PULSE);
                m_relock  = 0;
                m_timeout = 0;
                seen1     = 1'b0;
                seen2     = 1'b0;
            end else begin
                bit ok;
                ok    = seen2;
                seen2 = seen1;
                seen1 = bus.pll_lock & bus.mmcm_lock;
                m_elapsed++;
                case (m_phase)
                    M_PULSE:  if (m_elapsed >= P) modelEnter(M_WAIT);
                    M_WAIT: begin
                        if (ok) modelEnter(M_STABLE);
                        else if (m_elapsed >= T) begin
                            modelEnter(M_PULSE);
                            m_timeout = (m_timeout >= 255) ? 255 : m_timeout + 1;
                        end
                    end
                    M_STABLE: begin
                        if (!ok) modelEnter(M_WAIT);
                        else if (m_elapsed >= S) modelEnter(M_RUN);
                    end
                    M_RUN: begin
                        if (!ok) begin
                            modelEnter(M_PULSE);
                            m_relock = (m_relock >= 255) ? 255 : m_relock + 1;
                        end
                    end
                endcase
            end
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Every cycle: DUT outputs against the model.
    initial begin
        forever begin
            @(negedge clk);
            checkOutput("cyc_clk_rst", int'(bus.clk_rst), int'(m_phase == M_PULSE));
            checkOutput("cyc_sys_rst", int'(bus.sys_rst), int'(m_phase != M_RUN));
            checkOutput("cyc_ready",   int'(bus.ready),   int'(m_phase == M_RUN));
            checkOutput("cyc_relock",  int'(bus.relock_count),  m_relock);
            checkOutput("cyc_timeout", int'(bus.timeout_count), m_timeout);
        end
    end

    task automatic applyStimulus(input logic pll, input logic mmcm);
        bus.pll_lock  = pll;
        bus.mmcm_lock = mmcm;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int hold;
        int n;
        applyStimulus(1'b0, 1'b0);
        tick(3);
        checkOutput("rst_clk_rst", int'(bus.clk_rst), 1);
        checkOutput("rst_sys_rst", int'(bus.sys_rst), 1);
        checkOutput("rst_ready",   int'(bus.ready), 0);
        checkOutput("rst_counts",  int'(bus.relock_count) + int'(bus.timeout_count), 0);
        rst = 1'b0;

        // Power-up with no lock: pulse, full timeout, second pulse.
        tick(3);
        checkOutput("pwr_pulse_hi_e3", int'(bus.clk_rst), 1);
        tick(1);
        checkOutput("pwr_pulse_lo_e4", int'(bus.clk_rst), 0);
        tick(19);
        checkOutput("pwr_wait_lo_e23", int'(bus.clk_rst), 0);
        checkOutput("pwr_tmo_e23", int'(bus.timeout_count), 0);
        tick(1);
        checkOutput("pwr_pulse2_e24", int'(bus.clk_rst), 1);
        checkOutput("pwr_tmo_e24", int'(bus.timeout_count), 1);
        tick(4);
        checkOutput("pwr_pulse2_end_e28", int'(bus.clk_rst), 0);

        // Clean lock raised 5 cycles into WAIT_LOCK, sampled at edge 34.
        tick(5);
        applyStimulus(1'b1, 1'b1);
        tick(10);
        checkOutput("lock_sys_rst_e43", int'(bus.sys_rst), 1);
        tick(1);
        checkOutput("lock_sys_rst_e44", int'(bus.sys_rst), 0);
        checkOutput("lock_ready_e44", int'(bus.ready), 1);
        checkOutput("lock_relock_e44", int'(bus.relock_count), 0);

        // Loss in RUN: pll low sampled at edge 47, resets rise at 49.
        tick(2);
        applyStimulus(1'b0, 1'b1);
        tick(2);
        checkOutput("loss_sys_rst_e48", int'(bus.sys_rst), 0);
        checkOutput("loss_clk_rst_e48", int'(bus.clk_rst), 0);
        tick(1);
        checkOutput("loss_sys_rst_e49", int'(bus.sys_rst), 1);
        checkOutput("loss_clk_rst_e49", int'(bus.clk_rst), 1);
        checkOutput("loss_relock_e49", int'(bus.relock_count), 1);
        applyStimulus(1'b1, 1'b1);
        tick(3);
        checkOutput("loss_pulse_e52", int'(bus.clk_rst), 1);
        tick(1);
        checkOutput("loss_pulse_end_e53", int'(bus.clk_rst), 0);

        // STABLE from edge 54; one-cycle mmcm glitch lands on the terminal count.
        tick(6);
        applyStimulus(1'b1, 1'b0);
        tick(1);
        applyStimulus(1'b1, 1'b1);
        for (int e = 61; e <= 70; e++) begin
            tick(1);
            checkOutput("glitch_no_pulse", int'(bus.clk_rst), 0);
            checkOutput("glitch_sys_rst", int'(bus.sys_rst), 1);
        end
        tick(1);
        checkOutput("glitch_release_e71", int'(bus.sys_rst), 0);

        // Lock arrives exactly on the timeout terminal count (edge 99).
        tick(1);
        applyStimulus(1'b0, 1'b1);
        tick(24);
        applyStimulus(1'b1, 1'b1);
        tick(2);
        checkOutput("tie_clk_rst_e98", int'(bus.clk_rst), 0);
        tick(1);
        checkOutput("tie_clk_rst_e99", int'(bus.clk_rst), 0);
        checkOutput("tie_tmo_e99", int'(bus.timeout_count), 1);
        checkOutput("tie_relock_e99", int'(bus.relock_count), 2);
        tick(7);
        checkOutput("tie_sys_rst_e106", int'(bus.sys_rst), 1);
        tick(1);
        checkOutput("tie_sys_rst_e107", int'(bus.sys_rst), 0);

        // Saturation: hundreds of timeouts with locks held low.
        applyStimulus(1'b0, 1'b0);
        tick(300 * (P + T) + 30);
        checkOutput("sat_timeout", int'(bus.timeout_count), 255);
        checkOutput("sat_relock", int'(bus.relock_count), 3);

        // Async reset in the middle of STABLE.
        applyStimulus(1'b1, 1'b1);
        n = 0;
        while (m_phase != M_STABLE && n < 100) begin
            tick(1);
            n++;
        end
        checkOutput("reach_stable", int'(m_phase == M_STABLE), 1);
        tick(3);
        #1 rst = 1'b1;
        #1;
        checkOutput("arst_clk_rst", int'(bus.clk_rst), 1);
        checkOutput("arst_sys_rst", int'(bus.sys_rst), 1);
        checkOutput("arst_ready",   int'(bus.ready), 0);
        checkOutput("arst_timeout", int'(bus.timeout_count), 0);
        #1 rst = 1'b0;
        tick(3);
        checkOutput("arst_pulse_e3", int'(bus.clk_rst), 1);
        tick(1);
        checkOutput("arst_pulse_e4", int'(bus.clk_rst), 0);
        tick(8);
        checkOutput("arst_sys_rst_e12", int'(bus.sys_rst), 1);
        tick(1);
        checkOutput("arst_sys_rst_e13", int'(bus.sys_rst), 0);

        // Randomized lock activity with occasional async resets.
        hold = 0;
        for (int c = 0; c < 3000; c++) begin
            tick(1);
            if (hold == 0) begin
                applyStimulus(logic'($urandom_range(0, 99) < 85),
                              logic'($urandom_range(0, 99) < 85));
                hold = int'($urandom_range(1, 40));
            end
            hold--;
            if ($urandom_range(0, 499) == 0) begin
                #1 rst = 1'b1;
                #1 rst = 1'b0;
            end
        end

        tick(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
